counter_arbiter: RTL and testbench
==================================

Name: counter_arbiter

Overview:
- Shares one modulo-MAX up-counter among N_REQ requesters, using it as a timed resource.
- Round-robin arbitration selects one owner. The owner's start value is loaded into the counter, and the counter runs until it reaches MAX-1.
- The owner then gets a done pulse and the next requester is granted with no gap cycle.
- Used by pipeline-side units that need exclusive multi-cycle timing windows.

Parameters:
N_REQ, 4, number of requesters (>=2)
MAX, 12, counter modulus; the counter counts 0..MAX-1
WIDTH, $clog2(MAX), counter and start-value width (derived, not overridden)
IDX_W, $clog2(N_REQ), owner index width (derived)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low
req  in  N_REQ  per-requester request, level; held until done or withdrawn
start_value  in  N_REQ x WIDTH  per-requester counter load value
pause  in  1  freezes the counter while in RUN
grant  out  N_REQ  one-hot owner indication
done  out  N_REQ  one-cycle completion pulse to the owner
busy  out  1  high in LOAD, RUN and DONE
owner  out  IDX_W  current owner index; meaningful only while busy
q  out  WIDTH  shared counter value

Behaviour:
- Reset (reset==0, asynchronous, immediate): state IDLE; grant=0, done=0, busy=0, owner=0, q=0; rr pointer=N_REQ-1, so requester 0 has first priority.
- Arbitration: among asserted req bits, pick the first index after the rr pointer, wrapping. It is evaluated in IDLE and in DONE.
- IDLE: on any req, register the winner into owner and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - grant[owner]=1.
  - q <= min(start_value[owner], MAX-1); values >=MAX clamp to MAX-1.
  - pause has no effect.
  - Go to RUN.
- RUN:
  - If pause: q holds and the state holds.
  - Else if q==MAX-1: go to DONE; q holds and never wraps.
  - Else: q <= q+1.
- DONE (1 cycle):
  - done[owner]=1; grant[owner] stays 1.
  - rr pointer <= owner.
  - Arbitrate again with the updated pointer. If any req is asserted, go to LOAD for the winner; else go to IDLE.
  - The current owner's still-high req is lowest priority.
- Latency with no pause: grant is high for MAX-s+2 cycles (LOAD, MAX-s RUN cycles, DONE), where s is the clamped start value. From req sampled in IDLE, LOAD is the next cycle.
- Withdrawal: req[owner]==0 in LOAD or RUN causes the following behaviour.
  - Next state is IDLE; grant drops next cycle.
  - No done pulse is issued.
  - q holds its value.
  - rr pointer <= owner.
  - In DONE, withdrawal is ignored and done still pulses.
- Simultaneous events:
  - Withdrawal and pause together: withdrawal wins.
  - q==MAX-1 reached and pause in the same RUN cycle: pause wins; DONE is entered on the first unpaused cycle.
- start_value is sampled only in LOAD; later changes are ignored.
- q is not cleared between owners; each LOAD overwrites it.
- grant and done are never asserted for a non-owner, and each is at most one-hot.
- Reset mid-operation: all outputs return to reset values immediately; no done pulse is issued for the aborted owner.

Decomposition:
- Shared package counter_arbiter_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE};
  - the clamp helper function;
  - default constants N_REQ/MAX.
- One combinational sub-module, rr_pick, takes req and pointer and returns valid and index. It is reusable by other arbiters.
- The counter register, clamp and FSM live in counter_arbiter.

Test Plan:
1. MAX=12, req[0]=1, s=5: LOAD at cycle 1; q=5..11 over cycles 2-8; done[0] pulses in cycle 9; grant[0] is high for exactly 9 cycles; busy falls at cycle 10 after req drops.
2. All four req high, s=10 each: grants in order 0,1,2,3, each 4 cycles, back-to-back with no IDLE gap; each done pulses once.
3. Round-robin: after owner 1 completes with req[0] and req[1] both still high, the next grant goes to 0; after 0 completes, 1 is granted.
4. Clamp: s=15 (>=MAX) loads q=11; done is in the next cycle after the single RUN cycle; total grant is 3 cycles.
5. Pause for 3 cycles while q=7 in RUN: q stays 7 for those cycles and grant is extended by 3 cycles. Pause on the cycle q==11: DONE is delayed until pause drops.
6. Fault paths:
   - Drop req[2] while q=6: grant clears the next cycle, no done, q stays 6, and the next grant goes to 3 if requesting.
   - Assert reset mid-RUN: grant, done, busy, owner and q are 0 immediately.
   - After reset is released, req[0] has priority.

Source files
------------

// File: rtl/counter_arbiter_pkg.sv
// Shared types and helpers for the counter arbiter.
// State enum, default sizing and start-value clamp.
package counter_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_MAX   = 12;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // Start values at or above the modulus saturate to the top count.
  function automatic int unsigned clamp_start(
    input int unsigned s,
    input int unsigned max
  );
    return (s >= max) ? max - 1 : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request after ptr.
// Pure combinational, wraps around the request vector.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan ptr+1 .. ptr+N, keeping the first hit.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 1; i <= N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[W'(j)]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Shared modulo counter handed out as a timed window.
// Round-robin owner, load, count to top, done pulse.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int MAX   = DEF_MAX,
  localparam int WIDTH = $clog2(MAX),
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0][WIDTH-1:0] start_value,
  input  logic                        pause,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            done,
  output logic                        busy,
  output logic [IDX_W-1:0]            owner,
  output logic [WIDTH-1:0]            q
);

  localparam logic [WIDTH-1:0] QTOP = WIDTH'(MAX - 1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] rr, rr_nx;
  logic [IDX_W-1:0] owner_nx;
  logic [IDX_W-1:0] ptr;
  logic [WIDTH-1:0] q_nx;
  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic             held;

  // In DONE the finishing owner becomes the pointer at once.
  assign ptr  = (state == DONE) ? owner : rr;
  assign held = req[owner];

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (win_vld),
    .idx   (win_idx)
  );

  // State, owner, pointer and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr    <= IDX_W'(N_REQ - 1);
      owner <= '0;
      q     <= '0;
    end else begin
      state <= state_nx;
      rr    <= rr_nx;
      owner <= owner_nx;
      q     <= q_nx;
    end
  end

  // Next-state: arbitration, load, count, withdrawal.
  always_comb begin
    state_nx = state;
    rr_nx    = rr;
    owner_nx = owner;
    q_nx     = q;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          owner_nx = win_idx;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (!held) begin
          rr_nx    = owner;
          state_nx = IDLE;
        end else begin
          q_nx = WIDTH'(clamp_start(
            32'(start_value[owner]), MAX));
          state_nx = RUN;
        end
      end
      RUN: begin
        if (!held) begin
          rr_nx    = owner;
          state_nx = IDLE;
        end else if (pause) begin
          q_nx = q;
        end else if (q == QTOP) begin
          state_nx = DONE;
        end else begin
          q_nx = q + WIDTH'(1);
        end
      end
      DONE: begin
        rr_nx = owner;
        if (win_vld) begin
          owner_nx = win_idx;
          state_nx = LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Owner-qualified grant/done and busy flag.
  always_comb begin
    grant = '0;
    done  = '0;
    busy  = (state != IDLE);
    if (busy) grant[owner] = 1'b1;
    if (state == DONE) done[owner] = 1'b1;
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: directed windows plus
// random traffic against a window-level reference model.
module tb_counter_arbiter;

  localparam int N   = 4;
  localparam int MAX = 12;
  localparam int W   = 4;
  localparam int IW  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N-1:0][W-1:0] start_value;
  logic              pause;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic              busy;
  logic [IW-1:0]     owner;
  logic [W-1:0]      q;

  int n_tests = 0;
  int n_fail  = 0;

  // model: window owner, whether in its load or final cycle
  bit m_act, m_load, m_fin;
  int m_own, m_q, m_ptr;

  always #5 clock = ~clock;

  counter_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .start_value (start_value),
    .pause       (pause),
    .grant       (grant),
    .done        (done),
    .busy        (busy),
    .owner       (owner),
    .q           (q)
  );

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 0; m_load = 0; m_fin = 0;
    m_own = 0; m_q = 0; m_ptr = N - 1;
  endtask

  task automatic model_step();
    int s;
    if (!m_act) begin
      if (req != 0) begin
        m_own = pick(req, m_ptr);
        m_act = 1; m_load = 1;
      end
    end else if (m_fin) begin
      m_ptr = m_own;
      m_fin = 0;
      if (req != 0) begin
        m_own = pick(req, m_ptr);
        m_load = 1;
      end else begin
        m_act = 0;
      end
    end else if (!req[m_own]) begin
      m_act = 0; m_load = 0;
      m_ptr = m_own;
    end else if (m_load) begin
      s = int'(start_value[m_own]);
      m_q = (s > MAX - 1) ? MAX - 1 : s;
      m_load = 0;
    end else if (pause) begin
      m_q = m_q;
    end else if (m_q == MAX - 1) begin
      m_fin = 1;
    end else begin
      m_q = m_q + 1;
    end
  endtask

  task automatic check_all();
    chk("grant", int'(grant), m_act ? (1 << m_own) : 0);
    chk("done", int'(done), (m_act && m_fin) ? (1 << m_own) : 0);
    chk("busy", int'(busy), int'(m_act));
    if (m_act) chk("owner", int'(owner), m_own);
    chk("q", int'(q), m_q);
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    pause = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic async_reset_check(string tag);
    #2 reset = 1'b0;
    #1;
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_owner"}, int'(owner), 0);
    chk({tag, "_q"}, int'(q), 0);
    model_reset();
    @(negedge clock);
  endtask

  initial begin
    int gcnt;
    reset = 1'b0;
    req = '0;
    pause = 1'b0;
    start_value = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_q", int'(q), 0);
    reset = 1'b1;

    // single owner, s=5
    start_value[0] = 4'd5;
    req = 4'b0001;
    gcnt = 0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (grant[0]) gcnt++;
      if (c >= 2 && c <= 8) chk("t1_q", int'(q), c + 3);
      if (c == 9) begin
        chk("t1_done", int'(done), 1);
        req = '0;
      end
    end
    chk("t1_gcnt", gcnt, 9);
    tick();
    chk("t1_busy", int'(busy), 0);

    // reset mid-RUN, then requester 0 first
    do_reset();
    start_value[0] = 4'd3;
    req = 4'b0001;
    repeat (3) tick();
    async_reset_check("t6r");
    req = 4'b1001;
    reset = 1'b1;
    tick();
    chk("t6r_prio", int'(grant), 1);

    // all four, s=10: 4-cycle windows back to back
    do_reset();
    for (int i = 0; i < N; i++) start_value[i] = 4'd10;
    req = 4'b1111;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk("t2_grant", int'(grant), 1 << ((t - 1) / 4));
    end

    // round robin between 1 and 0
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b0011;
    repeat (3) tick();
    chk("t3_done1", int'(done), 2);
    tick();
    chk("t3_next0", int'(grant), 1);
    repeat (3) tick();
    chk("t3_done0", int'(done), 1);
    tick();
    chk("t3_next1", int'(grant), 2);

    // clamp: s=15 loads 11
    do_reset();
    start_value[0] = 4'd15;
    req = 4'b0001;
    tick();
    tick();
    chk("t4_q", int'(q), 11);
    tick();
    chk("t4_done", int'(done), 1);
    req = '0;
    tick();
    chk("t4_idle", int'(busy), 0);

    // pause at q=7 and at q=11
    do_reset();
    start_value[0] = 4'd5;
    req = 4'b0001;
    repeat (4) tick();
    chk("t5_q7", int'(q), 7);
    pause = 1'b1;
    repeat (3) tick();
    chk("t5_hold", int'(q), 7);
    pause = 1'b0;
    repeat (4) tick();
    chk("t5_q11", int'(q), 11);
    pause = 1'b1;
    repeat (2) tick();
    chk("t5_nodone", int'(done), 0);
    pause = 1'b0;
    tick();
    chk("t5_done", int'(done), 1);
    req = '0;
    tick();

    // withdrawal of owner 2 at q=6
    do_reset();
    start_value[2] = 4'd3;
    start_value[3] = 4'd8;
    req = 4'b0100;
    repeat (5) tick();
    chk("t6_q6", int'(q), 6);
    req = 4'b1000;
    tick();
    chk("t6_grant", int'(grant), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_qhold", int'(q), 6);
    tick();
    chk("t6_next3", int'(grant), 8);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset_check("rnd_rst");
        reset = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 3) == 0)
          start_value[i] = W'($urandom_range(0, 15));
      end
      pause = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
